lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_pkg.sv | 21 ++
 rtl/lfsr_checker.sv | 124 ++++++++++++
 tb/tb_lfsr_checker.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the x^16+x^14+x^13+x^12+1 LFSR generator and checker.
// Taps are numbered on the 16-bit register; s[15] holds the oldest bit.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam int unsigned TAP_A  = 15;
    localparam int unsigned TAP_B  = 13;
    localparam int unsigned TAP_C  = 12;
    localparam int unsigned TAP_D  = 11;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        VERIFY  = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic lfsr_next_fb(input logic [LFSR_W-1:0] s);
        return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Serial LFSR sequence checker: acquires the shadow register, verifies predictions,
// then free-runs while locked and counts mispredictions.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_MATCHES = 16,
    parameter int unsigned LOSS_ERRORS  = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state_o
);

    localparam int unsigned FILL_W  = $clog2(LFSR_W + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_MATCHES + 1);
    localparam int unsigned LOSS_W  = $clog2(LOSS_ERRORS + 1);

    state_t             r_state;
    logic [LFSR_W-1:0]  r_shadow;
    logic [FILL_W-1:0]  r_fill;
    logic [MATCH_W-1:0] r_match;
    logic [LOSS_W-1:0]  r_consec;
    logic               r_locked;
    logic               r_err_pulse;
    logic [CNT_W-1:0]   r_err_count;

    logic w_expected;
    logic w_match;
    logic w_lock_err;

    assign w_expected = lfsr_next_fb(r_shadow);
    assign w_match    = (bit_in == w_expected);
    assign w_lock_err = bit_valid && (r_state == LOCKED) && !w_match;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state     <= ACQUIRE;
            r_shadow    <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_consec    <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            case (r_state)
                ACQUIRE: if (bit_valid) begin
                    r_shadow <= {r_shadow[LFSR_W-2:0], bit_in};
                    if (r_fill == FILL_W'(LFSR_W - 1)) begin
                        r_state <= VERIFY;
                        r_fill  <= '0;
                        r_match <= '0;
                    end else begin
                        r_fill <= r_fill + FILL_W'(1);
                    end
                end
                VERIFY: if (bit_valid) begin
                    r_shadow <= {r_shadow[LFSR_W-2:0], bit_in};
                    // An all-zero register is the LFSR lockup state: restart silently.
                    if (r_shadow == '0) begin
                        r_state <= ACQUIRE;
                        r_fill  <= '0;
                    end else if (w_match) begin
                        if (r_match == MATCH_W'(LOCK_MATCHES - 1)) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                            r_consec <= '0;
                        end else begin
                            r_match <= r_match + MATCH_W'(1);
                        end
                    end else begin
                        r_err_pulse <= 1'b1;
                        r_state     <= ACQUIRE;
                        r_fill      <= '0;
                    end
                end
                LOCKED: if (bit_valid) begin
                    r_shadow <= {r_shadow[LFSR_W-2:0], w_expected};
                    if (!w_match) begin
                        r_err_pulse <= 1'b1;
                        if (r_consec == LOSS_W'(LOSS_ERRORS - 1)) begin
                            r_state  <= ACQUIRE;
                            r_fill   <= '0;
                            r_locked <= 1'b0;
                            r_consec <= '0;
                        end else begin
                            r_consec <= r_consec + LOSS_W'(1);
                        end
                    end else begin
                        r_consec <= '0;
                    end
                end
                default: begin
                    r_state  <= ACQUIRE;
                    r_fill   <= '0;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_err_count <= '0;
        end else if (clear_cnt) begin
            r_err_count <= '0;
        end else if (w_lock_err && !(&r_err_count)) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign state_o   = r_state;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scenario bench for lfsr_checker with a recurrence-based generator and reference model.
module tb_lfsr_checker;

    localparam int unsigned LOCK_M = 16;
    localparam int unsigned LOSS_E = 4;
    localparam int unsigned CW     = 4;
    localparam int          CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          bit_in;
    logic          bit_valid;
    logic          clear_cnt;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_count;
    logic [1:0]    state_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // generator history (g[0] oldest) and model history of received/predicted bits
    bit g[$];
    bit hist[$];
    int m_mode, m_fill, m_match, m_consec, m_cnt;
    bit m_pulse;

    lfsr_checker #(.LOCK_MATCHES(LOCK_M), .LOSS_ERRORS(LOSS_E), .CNT_W(CW)) dut (
        .clk(clk), .rst_b(rst_b), .bit_in(bit_in), .bit_valid(bit_valid),
        .clear_cnt(clear_cnt), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic gen_seed(input logic [15:0] seed);
        g.delete();
        for (int i = 15; i >= 0; i--) g.push_back(seed[i]);
    endtask

    // a[n] = a[n-16] ^ a[n-14] ^ a[n-13] ^ a[n-12]
    task automatic gen_bit(output logic b);
        b = g[0] ^ g[2] ^ g[3] ^ g[4];
        g.push_back(b);
        void'(g.pop_front());
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 16; i++) hist.push_back(1'b0);
        m_mode = 0; m_fill = 0; m_match = 0; m_consec = 0; m_cnt = 0; m_pulse = 0;
    endtask

    task automatic model_update(input logic bv, input logic b, input logic clr);
        bit pred;
        bit zero;
        m_pulse = 0;
        pred = hist[0] ^ hist[2] ^ hist[3] ^ hist[4];
        zero = 1;
        foreach (hist[i]) if (hist[i]) zero = 0;
        if (bv) begin
            if (m_mode == 0) begin
                hist.push_back(b); void'(hist.pop_front());
                m_fill++;
                if (m_fill == 16) begin m_mode = 1; m_match = 0; end
            end else if (m_mode == 1) begin
                hist.push_back(b); void'(hist.pop_front());
                if (zero) begin
                    m_mode = 0; m_fill = 0;
                end else if (b == pred) begin
                    m_match++;
                    if (m_match == LOCK_M) begin m_mode = 2; m_consec = 0; end
                end else begin
                    m_pulse = 1; m_mode = 0; m_fill = 0;
                end
            end else begin
                hist.push_back(pred); void'(hist.pop_front());
                if (b != pred) begin
                    m_pulse = 1;
                    if (m_cnt < CMAX) m_cnt++;
                    m_consec++;
                    if (m_consec == LOSS_E) begin m_mode = 0; m_fill = 0; end
                end else begin
                    m_consec = 0;
                end
            end
        end
        if (clr) m_cnt = 0;
    endtask

    task automatic step(input logic bv, input logic b, input logic clr);
        bit_valid = bv; bit_in = b; clear_cnt = clr;
        model_update(bv, b, clr);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0; bit_valid = 1'b1; bit_in = 1'b1; clear_cnt = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        if ({locked, err_pulse, err_count, state_o} !== '0) begin
            $display("FAIL reset: got locked=%b pulse=%b cnt=%0d state=%0d, want all 0",
                     locked, err_pulse, err_count, state_o);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_lock_acquire();
        logic b;
        gen_seed(16'hACE1);
        for (int k = 1; k <= 32; k++) begin
            gen_bit(b);
            step(1'b1, b, 1'b0);
            if (locked !== (k == 32)) begin
                $display("FAIL lock_acquire bit %0d: locked=%b want %b", k, locked, k == 32);
                n_fail++;
            end
            n_cmp++;
            if (k == 16 && state_o !== 2'd1) begin
                $display("FAIL verify_entry: state=%0d want 1", state_o);
                n_fail++;
            end
            if (k == 16) n_cmp++;
        end
        if (err_count !== '0) begin
            $display("FAIL lock_cnt: cnt=%0d want 0", err_count); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_single_error();
        logic b;
        int extra;
        gen_bit(b);
        step(1'b1, ~b, 1'b0);
        if (err_pulse !== 1'b1 || err_count !== CW'(1) || locked !== 1'b1) begin
            $display("FAIL single_error: pulse=%b cnt=%0d locked=%b want 1/1/1",
                     err_pulse, err_count, locked);
            n_fail++;
        end
        n_cmp++;
        extra = 0;
        for (int k = 0; k < 100; k++) begin
            gen_bit(b);
            step(1'b1, b, 1'b0);
            if (err_pulse !== 1'b0) extra++;
        end
        if (extra != 0 || err_count !== CW'(1) || locked !== 1'b1) begin
            $display("FAIL single_error_after: pulses=%0d cnt=%0d locked=%b want 0/1/1",
                     extra, err_count, locked);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_loss_of_lock();
        logic b;
        step(1'b0, 1'b0, 1'b1);
        if (err_count !== '0 || locked !== 1'b1) begin
            $display("FAIL clear_idle: cnt=%0d locked=%b want 0/1", err_count, locked);
            n_fail++;
        end
        n_cmp++;
        for (int k = 1; k <= 4; k++) begin
            gen_bit(b);
            step(1'b1, ~b, 1'b0);
            if (err_pulse !== 1'b1 || locked !== (k < 4)) begin
                $display("FAIL loss err %0d: pulse=%b locked=%b want 1/%b",
                         k, err_pulse, locked, k < 4);
                n_fail++;
            end
            n_cmp++;
        end
        if (err_count !== CW'(4) || state_o !== 2'd0) begin
            $display("FAIL loss_final: cnt=%0d state=%0d want 4/0", err_count, state_o);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_recovery();
        logic b;
        for (int k = 1; k <= 32; k++) begin
            gen_bit(b);
            step(1'b1, b, 1'b0);
            if (locked !== (k == 32)) begin
                $display("FAIL recovery bit %0d: locked=%b want %b", k, locked, k == 32);
                n_fail++;
            end
            n_cmp++;
        end
        if (err_count !== CW'(4)) begin
            $display("FAIL recovery_cnt: cnt=%0d want 4", err_count); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_clear_priority();
        logic b;
        gen_bit(b);
        step(1'b1, ~b, 1'b1);
        if (err_pulse !== 1'b1 || err_count !== '0 || locked !== 1'b1) begin
            $display("FAIL clear_priority: pulse=%b cnt=%0d locked=%b want 1/0/1",
                     err_pulse, err_count, locked);
            n_fail++;
        end
        n_cmp++;
        gen_bit(b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic test_saturation();
        logic b;
        for (int k = 0; k < CMAX; k++) begin
            gen_bit(b); step(1'b1, ~b, 1'b0);
            gen_bit(b); step(1'b1, b, 1'b0);
        end
        if (err_count !== CW'(CMAX) || locked !== 1'b1) begin
            $display("FAIL saturate_fill: cnt=%0d locked=%b want %0d/1", err_count, locked, CMAX);
            n_fail++;
        end
        n_cmp++;
        gen_bit(b);
        step(1'b1, ~b, 1'b0);
        if (err_count !== CW'(CMAX) || err_pulse !== 1'b1) begin
            $display("FAIL saturate_hold: cnt=%0d pulse=%b want %0d/1", err_count, err_pulse, CMAX);
            n_fail++;
        end
        n_cmp++;
        gen_bit(b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic b;
        if (locked !== 1'b1) begin
            $display("FAIL reset_mid_pre: locked=%b want 1", locked); n_fail++;
        end
        n_cmp++;
        gen_bit(b);
        rst_b = 1'b0; bit_valid = 1'b1; bit_in = ~b; clear_cnt = 1'b0;
        @(posedge clk); #1;
        if ({locked, err_pulse, err_count, state_o} !== '0) begin
            $display("FAIL reset_mid: locked=%b pulse=%b cnt=%0d state=%0d want all 0",
                     locked, err_pulse, err_count, state_o);
            n_fail++;
        end
        n_cmp++;
        rst_b = 1'b1;
        model_reset();
    endtask

    task automatic test_lockup();
        bit seen0, seen1;
        int bad;
        seen0 = 0; seen1 = 0; bad = 0;
        do_reset();
        for (int k = 0; k < 200; k++) begin
            step(1'b1, 1'b0, 1'b0);
            if (locked !== 1'b0 || err_pulse !== 1'b0 || state_o === 2'd2) bad++;
            if (state_o === 2'd0) seen0 = 1;
            if (state_o === 2'd1) seen1 = 1;
        end
        if (bad != 0 || err_count !== '0 || !seen0 || !seen1) begin
            $display("FAIL lockup: bad=%0d cnt=%0d seen0=%b seen1=%b want 0/0/1/1",
                     bad, err_count, seen0, seen1);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_qualifier();
        logic b;
        int nvalid;
        int iter;
        nvalid = 0; iter = 0;
        do_reset();
        gen_seed(16'hACE1);
        while (nvalid < 32 && iter < 1000) begin
            iter++;
            if ($urandom_range(1, 0) == 1) begin
                gen_bit(b);
                step(1'b1, b, 1'b0);
                nvalid++;
            end else begin
                step(1'b0, 1'($urandom), 1'b0);
            end
            if (locked !== (nvalid >= 32) || err_pulse !== 1'b0) begin
                $display("FAIL qualifier valid=%0d: locked=%b pulse=%b want %b/0",
                         nvalid, locked, err_pulse, nvalid >= 32);
                n_fail++;
            end
            n_cmp++;
        end
        if (nvalid < 32) begin
            $display("FAIL qualifier_timeout: valid=%0d want 32", nvalid); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_random();
        logic b;
        logic bv;
        logic clr;
        do_reset();
        gen_seed(16'($urandom_range(16'hFFFF, 1)));
        for (int k = 0; k < 3000; k++) begin
            bv  = ($urandom_range(3, 0) != 0);
            clr = ($urandom_range(31, 0) == 0);
            if (bv) begin
                gen_bit(b);
                if ($urandom_range(47, 0) == 0) b = ~b;
            end else begin
                b = 1'($urandom);
            end
            step(bv, b, clr);
            if (locked !== (m_mode == 2) || err_pulse !== m_pulse ||
                err_count !== CW'(m_cnt) || state_o !== 2'(m_mode)) begin
                $display("FAIL random cyc %0d: locked=%b pulse=%b cnt=%0d state=%0d want %b/%b/%0d/%0d",
                         k, locked, err_pulse, err_count, state_o, m_mode == 2, m_pulse, m_cnt, m_mode);
                n_fail++;
            end
            n_cmp++;
        end
    endtask

    initial begin
        rst_b = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clear_cnt = 1'b0;
        model_reset();
        gen_seed(16'hACE1);
        test_reset();
        test_lock_acquire();
        test_single_error();
        test_loss_of_lock();
        test_recovery();
        test_clear_priority();
        test_saturation();
        test_reset_mid();
        test_lockup();
        test_qualifier();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
